// File: rtl/bp_be_issue_buffer.sv
`default_nettype none
// ============================================================================
// Module   : bp_be_issue_buffer
// Brief    : Replayable issue queue with write/read/checkpoint pointers.
//            Entries are issued at rptr, retired at cptr, and replayed by
//            rewinding rptr to the checkpoint.
// Revision : 1.0 - initial release
// ============================================================================
module bp_be_issue_buffer #(
    parameter int unsigned els_p        = 8,
    parameter int unsigned data_width_p = 128
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic [data_width_p-1:0]       data_i,
    input  logic                          v_i,
    output logic                          ready_and_o,
    output logic [data_width_p-1:0]       data_o,
    output logic                          v_o,
    input  logic                          yumi_i,
    input  logic                          cmt_i,
    input  logic                          roll_i,
    input  logic                          clr_i,
    output logic [$clog2(els_p+1)-1:0]    count_o
);

    localparam int unsigned c_IDX_W = $clog2(els_p);
    localparam int unsigned c_PTR_W = c_IDX_W + 1;
    localparam int unsigned c_CNT_W = $clog2(els_p + 1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE  = {{(c_PTR_W-1){1'b0}}, 1'b1};
    localparam logic [c_PTR_W-1:0] c_PTR_ZERO = '0;

    logic [data_width_p-1:0] r_mem [els_p];

    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_PTR_W-1:0] r_cptr;

    logic [c_PTR_W-1:0] w_wptr_nxt;
    logic [c_PTR_W-1:0] w_rptr_nxt;
    logic [c_PTR_W-1:0] w_cptr_nxt;
    logic [c_PTR_W-1:0] w_used;
    logic [c_IDX_W-1:0] w_widx;
    logic [c_IDX_W-1:0] w_ridx;
    logic               w_full;
    logic               w_enq;
    logic               w_deq;
    logic               w_drop;

    assign w_widx = r_wptr[c_IDX_W-1:0];
    assign w_ridx = r_rptr[c_IDX_W-1:0];

    // Full when the write pointer has lapped the checkpoint by exactly one wrap.
    assign w_full = (r_wptr[c_IDX_W-1:0] == r_cptr[c_IDX_W-1:0])
                 && (r_wptr[c_IDX_W]     != r_cptr[c_IDX_W]);

    assign ready_and_o = ~w_full;
    assign v_o         = (r_rptr != r_wptr) & ~roll_i & ~clr_i;
    assign data_o      = r_mem[w_ridx];
    assign w_used      = r_wptr - r_cptr;
    assign count_o     = c_CNT_W'(w_used);

    assign w_enq  = v_i & ~w_full & ~clr_i;
    assign w_deq  = yumi_i & v_o;
    assign w_drop = v_i & w_full & ~clr_i;

    always_comb begin
        w_wptr_nxt = r_wptr;
        w_rptr_nxt = r_rptr;
        w_cptr_nxt = r_cptr;
        if (clr_i) begin
            w_wptr_nxt = c_PTR_ZERO;
            w_rptr_nxt = c_PTR_ZERO;
            w_cptr_nxt = c_PTR_ZERO;
        end else begin
            if (w_enq) begin
                w_wptr_nxt = r_wptr + c_PTR_ONE;
            end
            if (cmt_i) begin
                w_cptr_nxt = r_cptr + c_PTR_ONE;
            end
            // Replay lands on the checkpoint as it will be after this cycle's commit.
            if (roll_i) begin
                w_rptr_nxt = w_cptr_nxt;
            end else if (w_deq) begin
                w_rptr_nxt = r_rptr + c_PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_wptr <= c_PTR_ZERO;
            r_rptr <= c_PTR_ZERO;
            r_cptr <= c_PTR_ZERO;
        end else begin
            r_wptr <= w_wptr_nxt;
            r_rptr <= w_rptr_nxt;
            r_cptr <= w_cptr_nxt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_enq && !reset_i) begin
            r_mem[w_widx] <= data_i;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            a_yumi_valid : assert (!(yumi_i && !v_o && !roll_i && !clr_i))
                else $error("bp_be_issue_buffer: yumi_i without v_o");
            a_cmt_issued : assert (!(cmt_i && !clr_i && (r_cptr == r_rptr)))
                else $error("bp_be_issue_buffer: cmt_i with nothing issued");
        end
    end

    // Enqueue attempts while full are silently dropped; track them as coverage.
    c_enq_dropped : cover property (@(posedge clk_i) disable iff (reset_i) w_drop);
`endif

endmodule
`default_nettype wire
